// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: multi-cycle shift-and-add floating-point multiplier with valid/ready handshakes
module fpu_mul_seq #(
    parameter int N_EXP  = 8,
    parameter int N_MANT = 22,
    localparam int W = 1 + N_EXP + N_MANT + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);
    localparam int M    = N_MANT + 2;
    localparam int CW   = $clog2(M + 1);
    localparam int EW   = N_EXP + 2;
    localparam int BIAS = (1 << (N_EXP - 1)) - 1;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << N_EXP) - 1);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d, zero_q, zero_d;
    logic [N_EXP-1:0]       ea_q, ea_d, eb_q, eb_d;
    logic [M-1:0]           ma_q, ma_d, mb_q, mb_d;
    logic [2*M-1:0]         acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           result_q, result_d;
    logic [M:0]             sum;
    logic                   top;
    logic signed [EW-1:0]   exp_s;
    logic [N_MANT:0]        mant;

    // Product normalisation: the top bit picks a one-place shift and exponent bump
    assign sum   = {1'b0, acc_q[2*M-1:M]} + (mb_q[0] ? {1'b0, ma_q} : '0);
    assign top   = acc_q[2*M-1];
    assign mant  = top ? acc_q[2*M-2 -: N_MANT+1] : acc_q[2*M-3 -: N_MANT+1];
    assign exp_s = {2'b00, ea_q} + {2'b00, eb_q} - EW'(BIAS) + EW'(top);

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;

    // Next-state and datapath update for each phase of the operation
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d  = A[W-1] ^ B[W-1];
                ea_d    = A[W-2 -: N_EXP];
                eb_d    = B[W-2 -: N_EXP];
                zero_d  = A[W-2 -: N_EXP] == '0 || B[W-2 -: N_EXP] == '0;
                ma_d    = {1'b1, A[N_MANT:0]};
                mb_d    = {1'b1, B[N_MANT:0]};
                acc_d   = '0;
                cnt_d   = CW'(M);
                state_d = MULT;
            end
            MULT: begin
                acc_d   = {sum, acc_q[M-1:1]};
                mb_d    = mb_q >> 1;
                cnt_d   = cnt_q - CW'(cnt_q != '0);
                state_d = cnt_q <= CW'(1) ? NORM : MULT;
            end
            NORM: begin
                result_d = zero_q || exp_s[EW-1] || exp_s == '0 ? {sign_q, (W-1)'(0)} :
                           exp_s >= E_MAX ? {sign_q, N_EXP'((1 << N_EXP) - 2), {(N_MANT+1){1'b1}}} :
                           {sign_q, exp_s[N_EXP-1:0], mant};
                state_d  = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so in-flight work is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_fpu_mul_seq.sv
// tb_fpu_mul_seq: vector table, random model comparison and handshake/reset sequences for fpu_mul_seq
module tb_fpu_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    fpu_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Spec rules in plain integer arithmetic: full product, pick leading bit, truncate
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        logic [22:0] m;
        int e;
        logic s;
        s = a[31] ^ b[31];
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        if (p[47]) begin m = p[46:24]; e = 1; end
        else begin m = p[45:23]; e = 0; end
        e += int'(a[30:23]) + int'(b[30:23]) - 127;
        if (a[30:23] == 0 || b[30:23] == 0 || e <= 0) return {s, 31'b0};
        if (e >= 255) return {s, 8'd254, 23'h7fffff};
        return {s, e[7:0], m};
    endfunction

    function automatic real f2r(input logic [31:0] x);
        real r;
        int e;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return x[31] ? -r : r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 60) begin tick(); g++; end
        in_valid = 1'b1;
        A = a;
        B = b;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        r = result;
    endtask

    initial begin
        vec_t vecs[7];
        logic [31:0] r;
        int lat;
        int spur;
        real ra, rb, rr;
        logic ok;
        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000};
        vecs[1] = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000};
        vecs[2] = '{32'h00000000, 32'h40490FDB, 32'h00000000};
        vecs[3] = '{32'h00800000, 32'h00800000, 32'h00000000};
        vecs[4] = '{32'h80800000, 32'h00800000, 32'h80000000};
        vecs[5] = '{32'h7F000000, 32'h7F000000, 32'h7F7FFFFF};
        vecs[6] = '{32'h40000000, 32'h40000000, 32'h40800000};

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, r, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd25);
            chk($sformatf("vec%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("vec%0d_ov_pulse", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
        end

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
            run_op(a, b, r, lat);
            chk($sformatf("rnd%0d_exact", i), r, model(a, b));
            ra = f2r(a);
            rb = f2r(b);
            rr = f2r(r);
            ok = ((rr - ra * rb) / (ra * rb) < 0.01) && ((rr - ra * rb) / (ra * rb) > -0.01);
            chk($sformatf("rnd%0d_real", i), 32'(ok), 32'd1);
            tick();
        end

        out_ready = 1'b0;
        run_op(32'h3FC00000, 32'h40000000, r, lat);
        chk("bp_latency", 32'(lat), 32'd25);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            A = 32'h40000000;
            B = 32'h40000000;
            tick();
            in_valid = 1'b0;
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_result", i), result, 32'h40400000);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        spur = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (out_valid) spur++; end
        chk("bp_no_ghost_op", 32'(spur), 32'd0);

        in_valid = 1'b1;
        A = 32'h3FC00000;
        B = 32'h3FC00000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (out_valid) spur++; end
        chk("mid_rst_no_spurious", 32'(spur), 32'd0);
        run_op(32'h40000000, 32'h40000000, r, lat);
        chk("post_rst_result", r, 32'h40800000);
        chk("post_rst_latency", 32'(lat), 32'd25);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
